mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter AW, default 16, memory address width.
REQ-003 SHALL have parameter DW, default 32, memory data width.
REQ-004 SHALL have parameter RD_DEPTH, default 8, maximum outstanding reads (power of 2).
REQ-005 SHALL have parameter MAX_BURST, default 16, maximum consecutive accepted beats before forced rotation when others wait; 0 = unlimited.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port r_req  input  NREQ  per-requester request, held until accepted.
REQ-009 SHALL have port r_write  input  NREQ  per-requester 1 = write, 0 = read.
REQ-010 SHALL have port r_addr  input  NREQ*AW  per-requester address; requester i at bits [i*AW +: AW].
REQ-011 SHALL have port r_wdata  input  NREQ*DW  per-requester write data; requester i at bits [i*DW +: DW].
REQ-012 SHALL have port r_ena  output  NREQ  per-requester state-machine enable (stall when 0).
REQ-013 SHALL have port r_rdata_vld  output  NREQ  per-requester read-data valid.
REQ-014 SHALL have port r_rdata  output  DW  read data, broadcast to all requesters.
REQ-015 SHALL have port m_req, m_write  output  1 each  memory request and direction.
REQ-016 SHALL have port m_addr  output  AW  memory address.
REQ-017 SHALL have port m_wdata  output  DW  memory write data.
REQ-018 SHALL have port m_ready  input  1  memory accepts the current m_req this cycle.
REQ-019 SHALL have port m_rdata_vld  input  1  memory read data valid; responses return in request order.
REQ-020 SHALL have port m_rdata  input  DW  memory read data.
REQ-021 SHALL have port err  output  1  sticky protocol error.

Function
REQ-022 SHALL implement FSM IDLE/OWN plus registers owner (log2 NREQ), rr_ptr, burst_cnt.
REQ-023 IDLE: SHALL pick the first requester with r_req=1 searching from rr_ptr upward (wrapping), enter OWN that cycle, clear burst_cnt.
REQ-024 OWN: beat accepted when r_req[owner]=1, slot free (m_req=0 or m_ready=1), and (r_write[owner]=1 or read FIFO not full).
REQ-025 On acceptance: SHALL load m_req=1, m_write, m_addr, m_wdata from owner next cycle and increment burst_cnt.
REQ-026 SHALL hold the m_* registers stable while m_req=1 and m_ready=0; SHALL clear m_req after m_ready=1 with no new acceptance.
REQ-027 SHALL release ownership (to IDLE, rr_ptr=owner+1 mod NREQ) when r_req[owner]=0, or when burst_cnt reaches MAX_BURST (MAX_BURST != 0) and another r_req is high.
REQ-028 r_ena[i] SHALL be combinational: 1 when r_req[i]=0 or beat i accepted this cycle, else 0.
REQ-029 Each accepted read SHALL push owner ID into an RD_DEPTH-entry in-order FIFO; writes SHALL NOT push.
REQ-030 On m_rdata_vld=1, r_rdata_vld[head]=1 same cycle (combinational), r_rdata=m_rdata, FIFO pops.
REQ-031 FIFO full: SHALL stall reads (r_ena=0) but still accept writes; simultaneous push and pop when full SHALL be allowed.
REQ-032 m_rdata_vld=1 with FIFO empty SHALL set err=1 (sticky until reset), no r_rdata_vld pulse.
REQ-033 Ownership release and new acceptance by another requester SHALL NOT occur in the same cycle (one-cycle IDLE bubble).

Reset
REQ-034 While rst=1 at clk edge: FSM=IDLE, owner=0, rr_ptr=0, burst_cnt=0, FIFO empty, m_req=0, m_write=0, m_addr=0, m_wdata=0, err=0.
REQ-035 While rst=1: r_ena=0 and r_rdata_vld=0; in-flight reads SHALL be discarded (later m_rdata_vld sets err only if FIFO empty).

Verification
REQ-036 Single read: r_req[0]=1, r_write=0, addr 0x0010, m_ready=1 -> m_req=1, m_addr=0x0010 two cycles later; m_rdata_vld with 0xCAFE -> r_rdata_vld[0]=1, r_rdata=0xCAFE.
REQ-037 Contention: r_req=2'b11 from reset -> requester 0 owns; after r_req[0] drops, requester 1 owns after one IDLE cycle; r_ena[1]=0 throughout the wait.
REQ-038 Burst limit: MAX_BURST=4, both requesting continuously -> exactly 4 beats of 0, then 4 of 1, alternating.
REQ-039 Backpressure and full: RD_DEPTH=8, m_rdata_vld=0, 9 reads -> 8 accepted, 9th stalls (r_ena=0); one m_rdata_vld -> 9th accepted next cycle.
REQ-040 Interleaved returns: reads from 0 then 1 outstanding -> first m_rdata_vld pulses r_rdata_vld[0], second pulses r_rdata_vld[1].
REQ-041 Error and reset: m_rdata_vld=1 with nothing outstanding -> err=1 next cycle and stays; rst pulse -> err=0, m_req=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between NREQ requesters.
// A requester is granted the port from IDLE with round-robin priority and
// keeps it until it drops its request or until it has had MAX_BURST beats
// while someone else is waiting. Read responses come back in request order,
// and a FIFO of requester IDs steers each one back to the requester that
// issued the read.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   r_req/r_write      per-requester request and direction (1 = write)
//   r_addr/r_wdata     per-requester address and write data, packed by index
//   r_ena              per-requester enable; 0 stalls that requester
//   r_rdata_vld        per-requester read-data strobe
//   r_rdata            read data, broadcast to all requesters
//   m_req/m_write      memory request and direction (registered)
//   m_addr/m_wdata     memory address and write data (registered)
//   m_ready            memory takes the current m_req this cycle
//   m_rdata_vld/m_rdata  in-order memory read response
//   err                sticky: a read response arrived with nothing outstanding
//
// state  | meaning
// S_IDLE | no owner; pick the next requester starting at r_rr_ptr
// S_OWN  | r_owner may issue beats to the memory port
module mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int RD_DEPTH  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      r_req,
  input  logic [NREQ-1:0]      r_write,
  input  logic [NREQ*AW-1:0]   r_addr,
  input  logic [NREQ*DW-1:0]   r_wdata,
  output logic [NREQ-1:0]      r_ena,
  output logic [NREQ-1:0]      r_rdata_vld,
  output logic [DW-1:0]        r_rdata,
  output logic                 m_req,
  output logic                 m_write,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_wdata,
  input  logic                 m_ready,
  input  logic                 m_rdata_vld,
  input  logic [DW-1:0]        m_rdata,
  output logic                 err
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  localparam logic [PW:0]   FIFO_CAP  = (PW + 1)'(RD_DEPTH);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_burst_cnt;
  logic [OW-1:0]   r_fifo [RD_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_fifo_cnt;

  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_pop;
  logic            w_push;
  logic [NREQ-1:0] w_own_mask;
  logic            w_others;
  logic            w_limit;
  logic            w_slot_free;
  logic            w_rd_ok;
  logic            w_accept;
  logic            w_release;
  logic            w_found;
  logic [OW-1:0]   w_pick;
  logic [OW-1:0]   w_next_ptr;

  always_comb begin
    w_fifo_empty = (r_fifo_cnt == '0);
    w_fifo_full  = (r_fifo_cnt == FIFO_CAP);
    w_pop        = !rst && m_rdata_vld && !w_fifo_empty;
    w_own_mask   = NREQ'(1) << r_owner;
    w_others     = |(r_req & ~w_own_mask);
    // Burst counter saturates at the limit, so a lone owner keeps streaming
    // and is released the moment anyone else shows up.
    w_limit      = (MAX_BURST != 0) && (r_burst_cnt == BURST_LIM) && w_others;
    w_slot_free  = !m_req || m_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise block.
    w_rd_ok      = r_write[r_owner] || !w_fifo_full || w_pop;
    w_accept     = !rst && (r_state == S_OWN) && r_req[r_owner] && !w_limit
                   && w_slot_free && w_rd_ok;
    w_push       = w_accept && !r_write[r_owner];
    w_release    = (r_state == S_OWN) && (!r_req[r_owner] || w_limit);
    w_next_ptr   = OW'((int'(r_owner) + 1) % NREQ);
    r_ena        = rst ? '0 : (~r_req | (w_accept ? w_own_mask : '0));
    r_rdata_vld  = w_pop ? (NREQ'(1) << r_fifo[r_rd_ptr]) : '0;
    r_rdata      = m_rdata;
  end

  // Round-robin search; descending loop so the entry closest to r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (r_req[idx]) begin
        w_found = 1'b1;
        w_pick  = OW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      m_req       <= 1'b0;
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      err         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_OWN;
            r_owner     <= w_pick;
            r_burst_cnt <= '0;
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept && (r_burst_cnt != BURST_LIM))
        r_burst_cnt <= r_burst_cnt + 1'b1;

      if (w_accept) begin
        m_req   <= 1'b1;
        m_write <= r_write[r_owner];
        m_addr  <= r_addr[r_owner*AW +: AW];
        m_wdata <= r_wdata[r_owner*DW +: DW];
      end else if (m_ready) begin
        m_req <= 1'b0;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (m_rdata_vld && w_fifo_empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_owner;
  end

endmodule
